mem_request_unit: RTL

Parametrised data/instruction memory request unit for the MIPS CPU. It sits between the pipeline and the cache/memory controller and accepts load/store requests into a DEPTH-entry in-order queue. It issues the requests one at a time as level REN/WEN held until `dhit`, and returns load data with a registered response pulse. It also gates `imemREN` and performs an orderly drain on halt.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/mem_request_unit_if.sv | 43 ++++
 rtl/memreq_fifo.sv | 51 +++++
 rtl/mem_request_unit.sv | 110 +++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, memory request bundle, request-unit states.
// Imported by the memory request unit, its queue and the bench.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic  write;
    word_t addr;
    word_t wdata;
  } memreq_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN,
    HALTED
  } reqstate_t;

endpackage

// File: rtl/mem_request_unit_if.sv
// Pipeline/memory bus of the request unit: request in, dmem/imem out, response.
// master = the unit, slave = pipeline plus memory side.
interface mem_request_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready;
  logic          halt_req;
  logic          ihit;
  logic          dhit;
  logic [DW-1:0] dmemload;
  logic          dmemREN;
  logic          dmemWEN;
  logic [AW-1:0] dmemaddr;
  logic [DW-1:0] dmemstore;
  logic          imemREN;
  logic          rsp_valid;
  logic          rsp_write;
  logic [DW-1:0] rsp_data;
  logic          halted;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  halt_req, ihit, dhit, dmemload,
    output req_ready, dmemREN, dmemWEN, dmemaddr,
    output dmemstore, imemREN,
    output rsp_valid, rsp_write, rsp_data, halted
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output halt_req, ihit, dhit, dmemload,
    input  req_ready, dmemREN, dmemWEN, dmemaddr,
    input  dmemstore, imemREN,
    input  rsp_valid, rsp_write, rsp_data, halted
  );

endinterface

// File: rtl/memreq_fifo.sv
// In-order request queue: push at tail, pop at head, wrapping pointers.
// Ports: CLK, nRST, push/din, pop, head, full, empty, count.
module memreq_fifo
  import cpu_types_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = memreq_t
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head  = mem[rd_ptr];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_request_unit.sv
// Memory request unit: queues loads/stores, issues one at a time until dhit,
// registers the response, gates imemREN and drains on halt. Ports: CLK, nRST, bus.
module mem_request_unit
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  mem_request_unit_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  reqstate_t     state;
  reqstate_t     next;
  req_t          din;
  req_t          head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          busy;

  assign busy = state == BUSY;

  assign bus.req_ready = !full && state != DRAIN &&
                         state != HALTED && !bus.halt_req;

  assign push = bus.req_valid && bus.req_ready;
  assign pop  = busy && bus.dhit;

  assign din = '{write: bus.req_write,
                 addr:  bus.req_addr,
                 wdata: bus.req_wdata};

  memreq_fifo #(
    .DEPTH (DEPTH),
    .T     (req_t)
  ) u_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next;
  end

  // Head leaves on this edge; stay BUSY if anything is left behind it
  // (including a same-cycle push), so queued requests go back to back.
  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (!empty)            next = BUSY;
        else if (bus.halt_req) next = DRAIN;
      end
      BUSY: begin
        if (bus.dhit) begin
          if (count > CW'(1) || push) next = BUSY;
          else if (bus.halt_req)      next = DRAIN;
          else                        next = IDLE;
        end
      end
      DRAIN:   next = HALTED;
      HALTED:  next = HALTED;
      default: next = IDLE;
    endcase
  end

  assign bus.dmemREN   = busy && !head.write;
  assign bus.dmemWEN   = busy && head.write;
  assign bus.dmemaddr  = busy ? head.addr  : '0;
  assign bus.dmemstore = busy ? head.wdata : '0;
  assign bus.imemREN   = state != HALTED;
  assign bus.halted    = state == HALTED;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_write <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      bus.rsp_valid <= pop;
      bus.rsp_write <= head.write;
      bus.rsp_data  <= bus.dmemload;
    end
  end

  cover property (@(posedge CLK) disable iff (!nRST)
    bus.ihit && busy);

endmodule
